md_ctrl: RTL and testbench
==========================

MD_CTRL -- requirements
Module: md_ctrl

Interface
REQ-001 Parameter MULT_LAT, default 5, busy cycles for mult/multu.
REQ-002 Parameter DIV_LAT, default 10, busy cycles for div/divu.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 e_valid  in  1  E-stage holds a valid instruction.
REQ-006 e_op  in  4  MD operation code, encodings from md_pkg (NONE, MULT, MULTU, DIV, DIVU, MTHI, MTLO, MFHI, MFLO).
REQ-007 e_rs, e_rt  in  32 each  forwarded operands.
REQ-008 kill  in  1  E-stage instruction is being flushed (exception/interrupt), suppresses issue.
REQ-009 md_hi, md_lo  in  32 each  HI/LO values from the multiply/divide unit.
REQ-010 md_start  out  1  one-cycle start pulse to the unit.
REQ-011 md_op  out  4  operation to the unit, valid with md_start.
REQ-012 md_d1, md_d2  out  32 each  operands to the unit, valid with md_start.
REQ-013 stall  out  1  freeze F/D/E and bubble M.
REQ-014 busy  out  1  unit occupied by a running mult/div.
REQ-015 rd_data  out  32  mfhi/mflo result for E-stage writeback.
REQ-016 rd_valid  out  1  rd_data valid this cycle.

Function
REQ-017 FSM states: IDLE, RUN; busy SHALL equal (state == RUN).
REQ-018 issue = e_valid & ~kill & ~stall & (e_op in MULT/MULTU/DIV/DIVU/MTHI/MTLO); md_start SHALL equal issue, combinationally.
REQ-019 On issue, md_op = e_op, md_d1 = e_rs, md_d2 = e_rt; when md_start = 0, md_op = NONE, md_d1 = md_d2 = 0.
REQ-020 IDLE -> RUN on issue of MULT/MULTU (counter := MULT_LAT) or DIV/DIVU (counter := DIV_LAT); MTHI/MTLO issue SHALL stay in IDLE.
REQ-021 In RUN, counter decrements each cycle; RUN -> IDLE on the edge where counter == 1, so busy is high exactly LAT cycles, starting the cycle after md_start.
REQ-022 stall = e_valid & (e_op != NONE) & busy; stall SHALL NOT depend on kill.
REQ-023 Back-to-back MD ops: second op (arriving the cycle after md_start) SHALL stall for LAT cycles and issue in the first IDLE cycle.
REQ-024 rd_valid = e_valid & ~busy & (e_op in MFHI/MFLO); rd_data = md_hi for MFHI, md_lo for MFLO, else 0.
REQ-025 kill while busy SHALL NOT abort the running operation; counter continues.
REQ-026 Divide by zero SHALL run full DIV_LAT; result is whatever the unit produces.
REQ-027 Counter width 4 bits; LAT parameters SHALL be in 1..15; counter never wraps.

Reset
REQ-028 reset = 0 SHALL immediately force state IDLE, counter 0; hence busy = 0, stall = 0, md_start = 0.
REQ-029 reset asserted mid-RUN SHALL abandon the operation; no completion is signalled after release.
REQ-030 First issue possible in the first cycle after reset deasserts.

Structure
REQ-031 md_pkg SHALL hold the e_op/md_op encodings, the state encoding and default latencies; md_ctrl and the unit SHALL both import it.
REQ-032 One sub-module natural: md_lat_cnt (load/decrement counter with done flag); the FSM and decode stay in md_ctrl.

Verification
REQ-033 After reset: e_valid = 1, MULT, e_rs = 0xFFFFFFFF, e_rt = 2 -> md_start = 1 one cycle, md_op = MULT, md_d1 = 0xFFFFFFFF, md_d2 = 2, busy high exactly 5 cycles.
REQ-034 DIV issued, then MFLO on the next cycle -> stall high 10 cycles, rd_valid = 1 in the first IDLE cycle with rd_data = md_lo.
REQ-035 MULT with kill = 1 -> md_start = 0, busy stays 0, stall = 0.
REQ-036 DIVU running, kill pulsed at cycle 3 -> busy still ends after cycle 10.
REQ-037 reset = 0 at cycle 4 of a DIV -> busy = 0 immediately; after release, MTHI issues same cycle with busy remaining 0.
REQ-038 MULTU then MULT back-to-back -> second md_start exactly 6 cycles after the first.

Source files
------------

// File: rtl/md_pkg.sv
// md_pkg: shared encodings and defaults for the multiply/divide control path
//   md_op_e    : E-stage / unit operation codes
//   md_state_e : controller FSM states
//   CNT_W      : latency counter width
//   *_LAT_DEF  : default busy latencies
package md_pkg;

    typedef enum logic [3:0] {
        OP_NONE  = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MTHI  = 4'd5,
        OP_MTLO  = 4'd6,
        OP_MFHI  = 4'd7,
        OP_MFLO  = 4'd8
    } md_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_e;

    localparam int CNT_W        = 4;
    localparam int MULT_LAT_DEF = 5;
    localparam int DIV_LAT_DEF  = 10;

    // Operations that are handed to the unit (long ops plus HI/LO writes).
    function automatic logic is_unit_op(input logic [3:0] op);
        return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) ||
               (op == OP_DIVU) || (op == OP_MTHI) || (op == OP_MTLO);
    endfunction

    // Operations that occupy the unit for multiple cycles.
    function automatic logic is_long_op(input logic [3:0] op);
        return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic is_div_op(input logic [3:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic is_mf_op(input logic [3:0] op);
        return (op == OP_MFHI) || (op == OP_MFLO);
    endfunction

endpackage

// File: rtl/md_lat_cnt.sv
// md_lat_cnt: loadable down-counter that flags its final busy cycle
//   clk, reset   : clock, async active-low reset
//   load_i       : load load_val_i this edge (priority over decrement)
//   load_val_i   : latency to load
//   done_o       : counter holds 1, i.e. the last busy cycle
module md_lat_cnt
    import md_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             done_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Saturates at zero so an idle counter never wraps.
    always_comb begin
        cnt_d = load_i ? load_val_i : (cnt_q != '0) ? cnt_q - CNT_W'(1) : cnt_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign done_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/md_ctrl.sv
// md_ctrl: E-stage multiply/divide issue, busy tracking, stall and HI/LO read
//   clk, reset        : clock, async active-low reset
//   e_valid, e_op     : E-stage instruction valid and MD operation
//   e_rs, e_rt        : forwarded operands
//   kill              : flush of the E-stage instruction, suppresses issue
//   md_hi, md_lo      : HI/LO values from the unit
//   md_start/op/d1/d2 : one-cycle issue to the unit
//   stall             : freeze F/D/E while an MD op waits on a busy unit
//   busy              : unit running a mult/div
//   rd_data, rd_valid : mfhi/mflo result
module md_ctrl
    import md_pkg::*;
#(
    parameter int MULT_LAT = MULT_LAT_DEF,
    parameter int DIV_LAT  = DIV_LAT_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        e_valid,
    input  logic [3:0]  e_op,
    input  logic [31:0] e_rs,
    input  logic [31:0] e_rt,
    input  logic        kill,
    input  logic [31:0] md_hi,
    input  logic [31:0] md_lo,
    output logic        md_start,
    output logic [3:0]  md_op,
    output logic [31:0] md_d1,
    output logic [31:0] md_d2,
    output logic        stall,
    output logic        busy,
    output logic [31:0] rd_data,
    output logic        rd_valid
);

    localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_LAT);
    localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_LAT);

    md_state_e        state_q;
    logic             issue;
    logic             issue_long;
    logic             cnt_done;
    logic [CNT_W-1:0] lat_val;

    assign busy = (state_q == ST_RUN);

    // Issue is gated by reset so nothing reaches the unit while held in reset.
    always_comb begin
        stall      = e_valid & (e_op != OP_NONE) & busy;
        issue      = reset & e_valid & ~kill & ~stall & is_unit_op(e_op);
        issue_long = issue & is_long_op(e_op);
        lat_val    = is_div_op(e_op) ? DIV_CNT : MULT_CNT;
        md_start   = issue;
        md_op      = issue ? e_op : OP_NONE;
        md_d1      = issue ? e_rs : '0;
        md_d2      = issue ? e_rt : '0;
        rd_valid   = e_valid & ~busy & is_mf_op(e_op);
        rd_data    = (e_op == OP_MFHI) ? md_hi : (e_op == OP_MFLO) ? md_lo : '0;
    end

    md_lat_cnt u_cnt (
        .clk        (clk),
        .reset      (reset),
        .load_i     (issue_long),
        .load_val_i (lat_val),
        .done_o     (cnt_done)
    );

    // Issue only happens while idle (a busy unit stalls every MD op), and
    // kill has no path here so a running op always finishes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                             state_q <= ST_IDLE;
        else if (state_q == ST_IDLE && issue_long) state_q <= ST_RUN;
        else if (state_q == ST_RUN && cnt_done)    state_q <= ST_IDLE;
    end

endmodule

// File: tb/tb_md_ctrl.sv
// tb_md_ctrl: directed and random checks of md_ctrl against a cycle-number model
module tb_md_ctrl;
    import md_pkg::*;

    localparam int ML = 5;
    localparam int DL = 10;

    logic        clk = 1'b0;
    logic        reset, e_valid, kill;
    logic [3:0]  e_op;
    logic [31:0] e_rs, e_rt, md_hi, md_lo;
    logic        md_start, stall, busy, rd_valid;
    logic [3:0]  md_op;
    logic [31:0] md_d1, md_d2, rd_data;

    md_ctrl dut (
        .clk(clk), .reset(reset), .e_valid(e_valid), .e_op(e_op),
        .e_rs(e_rs), .e_rt(e_rt), .kill(kill), .md_hi(md_hi), .md_lo(md_lo),
        .md_start(md_start), .md_op(md_op), .md_d1(md_d1), .md_d2(md_d2),
        .stall(stall), .busy(busy), .rd_data(rd_data), .rd_valid(rd_valid)
    );

    always #5 clk = ~clk;

    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   busy_end = -1;
    int   start_cyc = 0;
    logic ob_start, ob_busy, ob_stall, ob_rdv;

    function automatic bit unit_op(input logic [3:0] op);
        return op inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One clock cycle: drive, check mid-cycle against the model, then advance.
    // The model records the last cycle the unit is busy: an op started in cycle c
    // keeps it busy for cycles c+1 .. c+LAT.
    task automatic step(input logic v, input logic [3:0] op, input logic [31:0] rs,
                        input logic [31:0] rt, input logic k, input logic rn);
        bit bz, st, iss;
        e_valid = v; e_op = op; e_rs = rs; e_rt = rt; kill = k; reset = rn;
        md_hi = $urandom; md_lo = $urandom;
        if (!rn) busy_end = -1;
        @(negedge clk);
        bz  = (cyc <= busy_end);
        st  = v && (op != OP_NONE) && bz;
        iss = rn && v && !k && !st && unit_op(op);
        chk("busy", {31'd0, busy}, {31'd0, bz});
        chk("stall", {31'd0, stall}, {31'd0, st});
        chk("md_start", {31'd0, md_start}, {31'd0, iss});
        chk("md_op", {28'd0, md_op}, iss ? {28'd0, op} : 32'd0);
        chk("md_d1", md_d1, iss ? rs : 32'd0);
        chk("md_d2", md_d2, iss ? rt : 32'd0);
        chk("rd_valid", {31'd0, rd_valid},
            {31'd0, v && !bz && (op == OP_MFHI || op == OP_MFLO)});
        chk("rd_data", rd_data, (op == OP_MFHI) ? md_hi : (op == OP_MFLO) ? md_lo : 32'd0);
        ob_start = md_start; ob_busy = busy; ob_stall = stall; ob_rdv = rd_valid;
        if (md_start) start_cyc = cyc;
        @(posedge clk);
        if (iss && op inside {OP_MULT, OP_MULTU}) busy_end = cyc + ML;
        if (iss && op inside {OP_DIV, OP_DIVU})   busy_end = cyc + DL;
        cyc++;
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, OP_NONE, 32'd0, 32'd0, 1'b0, 1'b1);
    endtask

    initial begin
        int cnt, s1;
        // Reset held with a valid MULT present: nothing may issue.
        step(1'b1, OP_MULT, 32'h1, 32'h2, 1'b0, 1'b0);
        step(1'b1, OP_MULT, 32'h1, 32'h2, 1'b0, 1'b0);

        // MULT right after reset: one start pulse, busy exactly ML cycles.
        step(1'b1, OP_MULT, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b1);
        chk("mult_start", {31'd0, ob_start}, 32'd1);
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            step(1'b0, OP_NONE, 32'd0, 32'd0, 1'b0, 1'b1);
            if (ob_busy) cnt++;
        end
        chk("mult_busy_len", cnt, ML);

        // DIV by zero followed by MFLO: MFLO stalls DL cycles then reads LO.
        step(1'b1, OP_DIV, 32'd77, 32'd0, 1'b0, 1'b1);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            step(1'b1, OP_MFLO, 32'd0, 32'd0, 1'b0, 1'b1);
            if (ob_stall) cnt++;
            if (ob_rdv) break;
        end
        chk("div_mflo_stall", cnt, DL);
        chk("mflo_valid", {31'd0, ob_rdv}, 32'd1);

        // Killed MULT never starts.
        step(1'b1, OP_MULT, 32'h5, 32'h6, 1'b1, 1'b1);
        chk("kill_start", {31'd0, ob_start}, 32'd0);
        idle(1);
        chk("kill_busy", {31'd0, ob_busy}, 32'd0);

        // Kill during DIVU does not shorten it.
        step(1'b1, OP_DIVU, 32'd9, 32'd3, 1'b0, 1'b1);
        cnt = 0;
        for (int i = 1; i <= 12; i++) begin
            step(i == 3, OP_MULT, 32'd1, 32'd1, i == 3, 1'b1);
            if (ob_busy) cnt++;
        end
        chk("divu_kill_len", cnt, DL);

        // Reset during cycle 4 of a DIV, then MTHI right after release.
        step(1'b1, OP_DIV, 32'd100, 32'd7, 1'b0, 1'b1);
        idle(3);
        step(1'b0, OP_NONE, 32'd0, 32'd0, 1'b0, 1'b0);
        chk("rst_mid_busy", {31'd0, ob_busy}, 32'd0);
        step(1'b1, OP_MTHI, 32'hABCD_0123, 32'd0, 1'b0, 1'b1);
        chk("mthi_start", {31'd0, ob_start}, 32'd1);
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            idle(1);
            if (ob_busy) cnt++;
        end
        chk("mthi_busy", cnt, 0);

        // MULTU then MULT back to back: second start ML+1 cycles later.
        step(1'b1, OP_MULTU, 32'd3, 32'd4, 1'b0, 1'b1);
        s1 = start_cyc;
        for (int i = 0; i < 12; i++) begin
            step(1'b1, OP_MULT, 32'd5, 32'd6, 1'b0, 1'b1);
            if (ob_start) break;
        end
        chk("b2b_gap", start_cyc - s1, ML + 1);
        idle(8);

        // Random traffic, checked every cycle by the model.
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 3) != 0, 4'($urandom_range(0, 8)), $urandom, $urandom,
                 $urandom_range(0, 7) == 0, $urandom_range(0, 63) != 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
